servo_ramp_ctrl: RTL and testbench
==================================

// Module: servo_ramp_ctrl
// PURPOSE
//  Upstream feeder for the 50 Hz PWM compare input. Takes a pulse-width command in
//  microseconds from the bus side, clamps it, scales it to clock counts, and slews the
//  compare value toward the target by a bounded step once per PWM frame. This avoids
//  servo current spikes from large jumps. compare changes only on a frame boundary,
//  so the PWM stage never sees a mid-frame update.
// PARAMETERS
//  CLK_MHZ   66         clock frequency in MHz; counts per microsecond
//  PERIOD    1_320_000  frame length in clk cycles (20 ms @ 66 MHz); must match PWM stage
//  MIN_US    500        lower clamp on commanded pulse width, us
//  MAX_US    2500       upper clamp on commanded pulse width, us
//  INIT_US   1500       pulse width after reset (servo neutral), us
//  STEP      660        max compare change per frame, counts; 0 = jump in one frame
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous reset, active-high
//  cmd_valid  in   1   cmd_us is valid
//  cmd_ready  out  1   block can accept a command this cycle
//  cmd_us     in   16  requested pulse width, us, unsigned
//  compare    out  32  compare value for the PWM stage, clk counts
//  frame_tick out  1   one-cycle pulse on the last cycle of each frame
//  busy       out  1   high while compare != target (ramp in progress)
// BEHAVIOUR
//  Reset (rst=1 at posedge): compare<=INIT_US*CLK_MHZ, target<=same, frame cnt<=0,
//   frame_tick<=0, busy<=0, cmd_ready<=0, state<=IDLE. cmd_ready=1 from first cycle after.
//  Frame counter: 0..PERIOD-1, wraps to 0. frame_tick=1 exactly when cnt==PERIOD-1.
//   Free-running, independent of commands.
//  Handshake: a command is accepted on a posedge with cmd_valid&&cmd_ready.
//   cmd_ready=0 only in CALC (and during reset). cmd_valid may stay high; no buffering.
//  Clamp: us_c = min(max(cmd_us,MIN_US),MAX_US). Captured into a register on accept.
//  FSM states: IDLE -> CALC on accept. RAMP -> CALC on accept (retarget).
//   CALC lasts 1 cycle: target<=us_c*CLK_MHZ (32-bit, no overflow for 16b*7b).
//   It then goes to RAMP, or to IDLE if the new target==compare.
//   RAMP -> IDLE when compare reaches target.
//  Slew: only on frame_tick cycles in RAMP.
//   d=|target-compare|. If d<=STEP or STEP==0: compare<=target, busy<=0, state<=IDLE.
//   Else compare<=compare+STEP (target>compare) or compare-STEP (target<compare).
//   Unsigned compare, no wrap: magnitude tested before subtract.
//  frame_tick during CALC: no compare update that frame; the slew resumes next tick.
//  Retarget mid-ramp: ramp restarts from current compare toward the new target.
//   No jump occurs.
//  busy: set in the cycle after CALC if target!=compare. Cleared in the same cycle
//   compare<=target.
//  compare is registered and changes only on frame_tick cycles or on reset.
//  Reset mid-ramp: all state returns to reset values on the next posedge.
// TESTING  (bench: CLK_MHZ=66, PERIOD=100, STEP=660 unless noted)
//  Reset release -> compare=99000, busy=0, frame_tick first at cycle 99, cmd_ready=1.
//  Send 2000 -> target 132000. Compare 99660,100320,... one step/tick. At tick 50 it
//   reaches 132000, busy falls, and there are no further changes.
//  Send 3000 -> clamped to 165000. Send 100 -> clamped to 33000. Ramp direction correct.
//  Retarget: at compare=105600 send 1500 -> next ticks 104940...99000, no overshoot.
//  STEP=0 build: send 2500 -> compare=165000 on first tick after CALC, busy 1 frame max.
//  Assert rst mid-ramp for 1 cycle -> compare=99000, cnt=0, busy=0 next cycle.
//   A cmd held valid is accepted once after release.

Source files
------------

// File: rtl/servo_ramp_ctrl.sv
// Servo pulse-width feeder: clamps a microsecond command, scales it to clock counts,
// and slews the PWM compare value toward it by a bounded step once per frame.
module servo_ramp_ctrl #(
    parameter int unsigned CLK_MHZ = 66,
    parameter int unsigned PERIOD  = 1_320_000,
    parameter int unsigned MIN_US  = 500,
    parameter int unsigned MAX_US  = 2500,
    parameter int unsigned INIT_US = 1500,
    parameter int unsigned STEP    = 660
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_us_i,
    output logic [31:0] compare_o,
    output logic        frame_tick_o,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | compare == target, waiting for a command
    // CALC  | one cycle: scale captured command into a new target
    // RAMP  | compare moving toward target, one step per frame tick
    typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;

    localparam int unsigned      CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [31:0]      INIT_CMP = 32'(INIT_US * CLK_MHZ);
    localparam logic [31:0]      STEP_C   = 32'(STEP);
    localparam logic [31:0]      SCALE_C  = 32'(CLK_MHZ);
    localparam logic [15:0]      MIN_C    = 16'(MIN_US);
    localparam logic [15:0]      MAX_C    = 16'(MAX_US);
    localparam bit               JUMP     = (STEP == 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    state_t      state_q;
    logic [15:0] us_q;
    logic [31:0] target_q;
    logic [31:0] compare_q;
    logic        busy_q;
    logic        ready_q;

    logic [15:0] us_c;
    logic        accept;
    logic        up;
    logic [31:0] diff;
    logic        snap;
    logic [31:0] stepped;
    logic [31:0] target_new;

    // Free-running frame counter; the tick is registered so it lines up with cnt == PERIOD-1.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        if (cmd_us_i < MIN_C) begin
            us_c = MIN_C;
        end else if (cmd_us_i > MAX_C) begin
            us_c = MAX_C;
        end else begin
            us_c = cmd_us_i;
        end
    end

    // Magnitude is formed before any subtraction so compare never wraps.
    always_comb begin
        accept     = cmd_valid_i && ready_q;
        up         = (target_q > compare_q);
        diff       = up ? (target_q - compare_q) : (compare_q - target_q);
        snap       = JUMP || (diff <= STEP_C);
        stepped    = up ? (compare_q + STEP_C) : (compare_q - STEP_C);
        target_new = 32'(us_q) * SCALE_C;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            us_q      <= 16'(INIT_US);
            target_q  <= INIT_CMP;
            compare_q <= INIT_CMP;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        us_q    <= us_c;
                        state_q <= CALC;
                        ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    target_q <= target_new;
                    busy_q   <= (target_new != compare_q);
                    state_q  <= (target_new == compare_q) ? IDLE : RAMP;
                    ready_q  <= 1'b1;
                end
                RAMP: begin
                    if (tick_q) begin
                        if (snap) begin
                            compare_q <= target_q;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            compare_q <= stepped;
                        end
                    end
                    // A retarget wins over the end-of-ramp transition; CALC re-evaluates busy.
                    if (accept) begin
                        us_q    <= us_c;
                        state_q <= CALC;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o  = ready_q;
    assign compare_o    = compare_q;
    assign frame_tick_o = tick_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl: one stepped instance (STEP=660) and one
// jump instance (STEP=0), both with PERIOD=100 and a shared clock and reset.
module tb_servo_ramp_ctrl;

    localparam int PER  = 100;
    localparam int STP  = 660;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_valid0;
    logic [15:0] cmd_us, cmd_us0;
    logic        cmd_ready, cmd_ready0;
    logic [31:0] compare, compare0;
    logic        frame_tick, frame_tick0;
    logic        busy, busy0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int tick_cyc = 0;
    int acc_cnt = 0;
    int acc0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (!rst && cmd_valid && cmd_ready) acc_cnt++;
    end

    servo_ramp_ctrl #(
        .CLK_MHZ(66), .PERIOD(PER), .MIN_US(500), .MAX_US(2500), .INIT_US(1500), .STEP(STP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_us_i(cmd_us), .compare_o(compare), .frame_tick_o(frame_tick), .busy_o(busy)
    );

    servo_ramp_ctrl #(
        .CLK_MHZ(66), .PERIOD(PER), .MIN_US(500), .MAX_US(2500), .INIT_US(1500), .STEP(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid0), .cmd_ready_o(cmd_ready0),
        .cmd_us_i(cmd_us0), .compare_o(compare0), .frame_tick_o(frame_tick0), .busy_o(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns one time unit after the posedge that ends the tick cycle.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < PER + 10; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                tick_cyc = cyc;
                break;
            end
        end
        chk("tick_timeout", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Returns after the CALC cycle has completed.
    task automatic send(input logic [15:0] us, input bit sel, input logic exp_busy);
        bit got = 1'b0;
        if (sel) begin
            cmd_us0 = us;
            cmd_valid0 = 1'b1;
        end else begin
            cmd_us = us;
            cmd_valid = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((sel ? cmd_ready0 : cmd_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_valid0 = 1'b0;
        chk("ready_in_calc", {31'd0, (sel ? cmd_ready0 : cmd_ready)}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_calc", {31'd0, (sel ? cmd_ready0 : cmd_ready)}, 32'd1);
        chk("busy_after_calc", {31'd0, (sel ? busy0 : busy)}, {31'd0, exp_busy});
    endtask

    task automatic ramp_check(input int start, input int tgt, input int nticks);
        int e = start;
        for (int k = 0; k < nticks; k++) begin
            wait_tick();
            if (e < tgt) e = (tgt - e <= STP) ? tgt : e + STP;
            else if (e > tgt) e = (e - tgt <= STP) ? tgt : e - STP;
            chk("ramp_compare", compare, e);
            chk("ramp_busy", {31'd0, busy}, {31'd0, (e != tgt)});
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_valid0 = 1'b0;
        cmd_us = 16'd0;
        cmd_us0 = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_compare", compare, 32'd99000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_compare0", compare0, 32'd99000);
        rst = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        wait_tick();
        chk("first_tick_cycle", tick_cyc - rel_cyc, 32'd99);
        chk("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
        chk("idle_compare", compare, 32'd99000);

        // Up-ramp to 132000, then hold.
        send(16'd2000, 1'b0, 1'b1);
        chk("no_jump_on_calc", compare, 32'd99000);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_frame_hold", compare, 32'd99000);
        ramp_check(99000, 132000, 52);

        // Down-ramp toward 33000 (clamped), retarget at 105600 to 99000.
        send(16'd100, 1'b0, 1'b1);
        ramp_check(132000, 33000, 40);
        chk("retarget_point", compare, 32'd105600);
        send(16'd1500, 1'b0, 1'b1);
        chk("retarget_no_jump", compare, 32'd105600);
        ramp_check(105600, 99000, 11);

        // Clamped-high up-ramp, interrupted by a one-cycle reset with cmd held valid.
        send(16'd3000, 1'b0, 1'b1);
        ramp_check(99000, 165000, 3);
        @(negedge clk);
        rst = 1'b1;
        cmd_us = 16'd2000;
        cmd_valid = 1'b1;
        acc0 = acc_cnt;
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        chk("midrst_compare", compare, 32'd99000);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midrst_tick", {31'd0, frame_tick}, 32'd0);
        send(16'd2000, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("held_cmd_once", acc_cnt - acc0, 32'd1);
        wait_tick();
        chk("midrst_tick_cycle", tick_cyc - rel_cyc, 32'd99);
        chk("midrst_first_step", compare, 32'd99660);

        // STEP=0 instance: full jump on the first tick after CALC.
        send(16'd2500, 1'b1, 1'b1);
        chk("jump_hold", compare0, 32'd99000);
        wait_tick();
        chk("jump_2500", compare0, 32'd165000);
        chk("jump_busy", {31'd0, busy0}, 32'd0);
        send(16'd100, 1'b1, 1'b1);
        wait_tick();
        chk("jump_clamp_low", compare0, 32'd33000);
        send(16'd3000, 1'b1, 1'b1);
        wait_tick();
        chk("jump_clamp_high", compare0, 32'd165000);
        send(16'd2600, 1'b1, 1'b0);
        wait_tick();
        chk("same_target_idle", compare0, 32'd165000);
        chk("same_target_busy", {31'd0, busy0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
